// File: rtl/cpu_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cpu_test_monitor
// Description : Run controller and commit monitor for the single-cycle RV32
//               core. Sequences the CPU reset, counts run cycles, keeps a
//               ring-buffer trace of recent PC/instruction pairs and decides
//               how a run ends: PASS/FAIL through a tohost store, HANG on a
//               PC self-loop, or TIMEOUT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   I_clk           clock, rising edge
//   I_rst           synchronous active-low reset
//   I_start         one-cycle pulse: begin or restart a run
//   I_pc/I_inst     committed PC and instruction of the CPU
//   I_memrw         CPU store strobe (1 = store)
//   I_mem_addr      store address
//   I_mem_wdata     store data
//   I_trace_idx     trace read index, 0 = newest entry
//   O_cpu_rst       active-high reset driven into the CPU
//   O_running       run in progress
//   O_done          any terminal state reached
//   O_pass/O_fail/O_hang/O_timeout  one-hot terminal flags
//   O_fail_code     tohost value >> 1 on FAIL, else 0
//   O_cycles        RUN cycles elapsed, saturating
//   O_trace_count   valid trace entries, saturates at TRACE_DEPTH
//   O_trace_pc/O_trace_inst  trace entry selected by I_trace_idx
// ============================================================================
module cpu_test_monitor #(
  parameter int              XLEN           = 32,
  parameter int              RESET_CYCLES   = 2,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              HANG_CYCLES    = 8,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int              TRACE_DEPTH    = 16,
  parameter int              CNT_W          = 32
) (
  input  logic                         I_clk,
  input  logic                         I_rst,
  input  logic                         I_start,
  input  logic [XLEN-1:0]              I_pc,
  input  logic [31:0]                  I_inst,
  input  logic                         I_memrw,
  input  logic [XLEN-1:0]              I_mem_addr,
  input  logic [XLEN-1:0]              I_mem_wdata,
  input  logic [$clog2(TRACE_DEPTH)-1:0] I_trace_idx,
  output logic                         O_cpu_rst,
  output logic                         O_running,
  output logic                         O_done,
  output logic                         O_pass,
  output logic                         O_fail,
  output logic                         O_hang,
  output logic                         O_timeout,
  output logic [XLEN-1:0]              O_fail_code,
  output logic [CNT_W-1:0]             O_cycles,
  output logic [$clog2(TRACE_DEPTH):0] O_trace_count,
  output logic [XLEN-1:0]              O_trace_pc,
  output logic [31:0]                  O_trace_inst
);

  localparam int IDXW = $clog2(TRACE_DEPTH);
  localparam int RCW  = $clog2(RESET_CYCLES) + 1;
  localparam int HCW  = $clog2(HANG_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_HANG    = 3'd5,
    ST_TIMEOUT = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [IDXW:0]     tcount_q, tcount_d;
  logic [IDXW-1:0]   wptr_q, wptr_d;
  logic [HCW-1:0]    hang_q, hang_d;
  logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
  logic              first_q, first_d;
  logic [XLEN-1:0]   fail_code_q, fail_code_d;

  // Output flags are registered from the next state so they change on the
  // same edge as the state register.
  logic cpu_rst_q, running_q, pass_q, fail_q, hang_flag_q, timeout_q;
  logic cpu_rst_d, running_d, pass_d, fail_d, hang_flag_d, timeout_d;

  logic [XLEN-1:0] trace_pc_q   [TRACE_DEPTH];
  logic [31:0]     trace_inst_q [TRACE_DEPTH];
  logic            trace_we;

  logic              pc_changed;
  logic              tohost_hit;
  logic [CNT_W:0]    cycles_inc;

  // The first RUN cycle has no previous PC, so it always counts as a change.
  assign pc_changed = first_q || (I_pc != prev_pc_q);
  assign tohost_hit = I_memrw && (I_mem_addr == TOHOST_ADDR);
  // One bit wider than the counter so the timeout compare is immune to
  // saturation wrap.
  assign cycles_inc = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    cycles_d    = cycles_q;
    tcount_d    = tcount_q;
    wptr_d      = wptr_q;
    hang_d      = hang_q;
    prev_pc_d   = prev_pc_q;
    first_d     = first_q;
    fail_code_d = fail_code_q;
    trace_we    = 1'b0;

    if (I_start) begin
      // Start from any state opens a fresh run with clean per-run state.
      state_d     = ST_RESET;
      rcnt_d      = RCW'(RESET_CYCLES - 1);
      cycles_d    = '0;
      tcount_d    = '0;
      wptr_d      = '0;
      hang_d      = '0;
      first_d     = 1'b1;
      fail_code_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rcnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            rcnt_d = rcnt_q - RCW'(1);
          end
        end

        ST_RUN: begin
          // The exiting cycle is traced and counted like any other.
          trace_we  = 1'b1;
          wptr_d    = wptr_q + IDXW'(1);
          if (tcount_q != (IDXW+1)'(TRACE_DEPTH)) begin
            tcount_d = tcount_q + (IDXW+1)'(1);
          end
          if (cycles_q != {CNT_W{1'b1}}) begin
            cycles_d = cycles_inc[CNT_W-1:0];
          end
          prev_pc_d = I_pc;
          first_d   = 1'b0;
          hang_d    = pc_changed ? '0 : hang_q + HCW'(1);

          if (tohost_hit) begin
            if (I_mem_wdata == XLEN'(1)) begin
              state_d = ST_PASS;
            end else begin
              state_d     = ST_FAIL;
              fail_code_d = I_mem_wdata >> 1;
            end
          end else if (!pc_changed && (hang_d == HCW'(HANG_CYCLES - 1))) begin
            state_d = ST_HANG;
          end else if (cycles_inc == (CNT_W+1)'(TIMEOUT_CYCLES)) begin
            state_d = ST_TIMEOUT;
          end
        end

        // IDLE and terminal states hold until the next start.
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    cpu_rst_d   = (state_d != ST_RUN);
    running_d   = (state_d == ST_RUN);
    pass_d      = (state_d == ST_PASS);
    fail_d      = (state_d == ST_FAIL);
    hang_flag_d = (state_d == ST_HANG);
    timeout_d   = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state_q     <= ST_IDLE;
      rcnt_q      <= '0;
      cycles_q    <= '0;
      tcount_q    <= '0;
      wptr_q      <= '0;
      hang_q      <= '0;
      prev_pc_q   <= '0;
      first_q     <= 1'b1;
      fail_code_q <= '0;
      cpu_rst_q   <= 1'b1;
      running_q   <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      hang_flag_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      cycles_q    <= cycles_d;
      tcount_q    <= tcount_d;
      wptr_q      <= wptr_d;
      hang_q      <= hang_d;
      prev_pc_q   <= prev_pc_d;
      first_q     <= first_d;
      fail_code_q <= fail_code_d;
      cpu_rst_q   <= cpu_rst_d;
      running_q   <= running_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      hang_flag_q <= hang_flag_d;
      timeout_q   <= timeout_d;
    end
  end

  // Trace storage needs no reset: entries beyond the valid count are masked.
  always_ff @(posedge I_clk) begin
    if (I_rst && trace_we) begin
      trace_pc_q[wptr_q]   <= I_pc;
      trace_inst_q[wptr_q] <= I_inst;
    end
  end

  // Newest entry sits just behind the write pointer.
  logic [IDXW-1:0] rd_ptr;
  logic            rd_valid;
  assign rd_ptr   = wptr_q - IDXW'(1) - I_trace_idx;
  assign rd_valid = ({1'b0, I_trace_idx} < tcount_q);

  assign O_trace_pc    = rd_valid ? trace_pc_q[rd_ptr]   : '0;
  assign O_trace_inst  = rd_valid ? trace_inst_q[rd_ptr] : '0;
  assign O_cpu_rst     = cpu_rst_q;
  assign O_running     = running_q;
  assign O_pass        = pass_q;
  assign O_fail        = fail_q;
  assign O_hang        = hang_flag_q;
  assign O_timeout     = timeout_q;
  assign O_done        = pass_q | fail_q | hang_flag_q | timeout_q;
  assign O_fail_code   = fail_code_q;
  assign O_cycles      = cycles_q;
  assign O_trace_count = tcount_q;

endmodule
`default_nettype wire
